// File: rtl/ctrl_pkg.sv
// Shared control-bus layout and forward-select encodings for the MIPS pipeline.
// Imported by the decoder, the datapath and ctrl_pipe.
package ctrl_pkg;

  localparam int ALUSRC   = 7;
  localparam int ALUOP_HI = 6;
  localparam int ALUOP_LO = 5;
  localparam int REGDST   = 4;
  localparam int MEMREAD  = 3;
  localparam int MEMWRITE = 2;
  localparam int MEMTOREG = 1;
  localparam int REGWRITE = 0;

  localparam logic [7:0] BUBBLE = 8'h00;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/ctrl_pipe_forward_unit.sv
// EX-stage operand forwarding selects; MEM result wins over WB result.
module forward_unit
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_wreg,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_wreg,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  // $0 is hard-wired, so a write to it is never a forwarding source
  function automatic logic [1:0] fwd_sel(
    input logic              m_rw,
    input logic [REG_AW-1:0] m_wr,
    input logic              w_rw,
    input logic [REG_AW-1:0] w_wr,
    input logic [REG_AW-1:0] src
  );
    if (m_rw && (m_wr != '0) && (m_wr == src)) return FWD_MEM;
    if (w_rw && (w_wr != '0) && (w_wr == src)) return FWD_WB;
    return FWD_RF;
  endfunction

  assign fwd_a = fwd_sel(mem_regwrite, mem_wreg, wb_regwrite, wb_wreg, ex_rs);
  assign fwd_b = fwd_sel(mem_regwrite, mem_wreg, wb_regwrite, wb_wreg, ex_rt);

endmodule

// File: rtl/ctrl_pipe.sv
// Carries decoder control fields through ID/EX, EX/MEM, MEM/WB, with
// load-use hazard detection and EX forwarding selects.
module ctrl_pipe
#(
  parameter int         REG_AW = 5,
  parameter logic [7:0] BUBBLE = ctrl_pkg::BUBBLE
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        Bus_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] IDRs_i,
  input  logic [REG_AW-1:0] IDRt_i,
  input  logic [REG_AW-1:0] IDRd_i,
  output logic              EX_ALUSrc_o,
  output logic [1:0]        EX_ALUOp_o,
  output logic [REG_AW-1:0] EX_WriteReg_o,
  output logic              MEM_MemRead_o,
  output logic              MEM_MemWrite_o,
  output logic [REG_AW-1:0] MEM_WriteReg_o,
  output logic              WB_MemtoReg_o,
  output logic              WB_RegWrite_o,
  output logic [REG_AW-1:0] WB_WriteReg_o,
  output logic              Hazard_o,
  output logic [1:0]        ForwardA_o,
  output logic [1:0]        ForwardB_o
);
  import ctrl_pkg::*;

  logic [7:0]        ex_bus;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd, ex_wreg;
  logic              mem_rd, mem_wr, mem_m2r, mem_rw;
  logic [REG_AW-1:0] mem_wreg;
  logic              wb_m2r, wb_rw;
  logic [REG_AW-1:0] wb_wreg;
  logic              hazard, squash;

  assign ex_wreg = ex_bus[REGDST] ? ex_rd : ex_rt;
  assign hazard  = ex_bus[MEMREAD] && (ex_wreg != '0) &&
                   ((ex_wreg == IDRs_i) || (ex_wreg == IDRt_i));
  assign squash  = flush_i | hazard;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_bus   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      mem_m2r  <= 1'b0;
      mem_rw   <= 1'b0;
      mem_wreg <= '0;
      wb_m2r   <= 1'b0;
      wb_rw    <= 1'b0;
      wb_wreg  <= '0;
    end else begin
      // a squashed slot also zeroes its register fields so it can never match
      ex_bus   <= squash ? BUBBLE : Bus_i;
      ex_rs    <= squash ? '0 : IDRs_i;
      ex_rt    <= squash ? '0 : IDRt_i;
      ex_rd    <= squash ? '0 : IDRd_i;
      mem_rd   <= ex_bus[MEMREAD];
      mem_wr   <= ex_bus[MEMWRITE];
      mem_m2r  <= ex_bus[MEMTOREG];
      mem_rw   <= ex_bus[REGWRITE];
      mem_wreg <= ex_wreg;
      wb_m2r   <= mem_m2r;
      wb_rw    <= mem_rw;
      wb_wreg  <= mem_wreg;
    end
  end

  forward_unit #(.REG_AW(REG_AW)) u_fwd (
    .mem_regwrite (mem_rw),
    .mem_wreg     (mem_wreg),
    .wb_regwrite  (wb_rw),
    .wb_wreg      (wb_wreg),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .fwd_a        (ForwardA_o),
    .fwd_b        (ForwardB_o)
  );

  assign EX_ALUSrc_o    = ex_bus[ALUSRC];
  assign EX_ALUOp_o     = ex_bus[ALUOP_HI:ALUOP_LO];
  assign EX_WriteReg_o  = ex_wreg;
  assign MEM_MemRead_o  = mem_rd;
  assign MEM_MemWrite_o = mem_wr;
  assign MEM_WriteReg_o = mem_wreg;
  assign WB_MemtoReg_o  = wb_m2r;
  assign WB_RegWrite_o  = wb_rw;
  assign WB_WriteReg_o  = wb_wreg;
  assign Hazard_o       = hazard;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: expectations queued at issue, checked when due.
module tb_ctrl_pipe;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] Bus_i;
  logic       flush_i;
  logic [4:0] IDRs_i, IDRt_i, IDRd_i;
  logic       EX_ALUSrc_o;
  logic [1:0] EX_ALUOp_o;
  logic [4:0] EX_WriteReg_o;
  logic       MEM_MemRead_o, MEM_MemWrite_o;
  logic [4:0] MEM_WriteReg_o;
  logic       WB_MemtoReg_o, WB_RegWrite_o;
  logic [4:0] WB_WriteReg_o;
  logic       Hazard_o;
  logic [1:0] ForwardA_o, ForwardB_o;

  ctrl_pipe #(.REG_AW(5), .BUBBLE(8'h00)) dut (
    .clk_i, .rst_i, .Bus_i, .flush_i, .IDRs_i, .IDRt_i, .IDRd_i,
    .EX_ALUSrc_o, .EX_ALUOp_o, .EX_WriteReg_o,
    .MEM_MemRead_o, .MEM_MemWrite_o, .MEM_WriteReg_o,
    .WB_MemtoReg_o, .WB_RegWrite_o, .WB_WriteReg_o,
    .Hazard_o, .ForwardA_o, .ForwardB_o
  );

  always #5 clk_i = ~clk_i;

  localparam int S_EX_ALUSRC = 0, S_EX_ALUOP = 1, S_EX_WREG = 2, S_MEM_RD = 3,
                 S_MEM_WR = 4, S_MEM_WREG = 5, S_WB_M2R = 6, S_WB_RW = 7,
                 S_WB_WREG = 8, S_HAZ = 9, S_FWDA = 10, S_FWDB = 11, S_ALL = 12;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_EX_ALUSRC: return 32'(EX_ALUSrc_o);
      S_EX_ALUOP:  return 32'(EX_ALUOp_o);
      S_EX_WREG:   return 32'(EX_WriteReg_o);
      S_MEM_RD:    return 32'(MEM_MemRead_o);
      S_MEM_WR:    return 32'(MEM_MemWrite_o);
      S_MEM_WREG:  return 32'(MEM_WriteReg_o);
      S_WB_M2R:    return 32'(WB_MemtoReg_o);
      S_WB_RW:     return 32'(WB_RegWrite_o);
      S_WB_WREG:   return 32'(WB_WriteReg_o);
      S_HAZ:       return 32'(Hazard_o);
      S_FWDA:      return 32'(ForwardA_o);
      S_FWDB:      return 32'(ForwardB_o);
      default:     return 32'({EX_ALUSrc_o, EX_ALUOp_o, EX_WriteReg_o, MEM_MemRead_o,
                               MEM_MemWrite_o, MEM_WriteReg_o, WB_MemtoReg_o,
                               WB_RegWrite_o, WB_WriteReg_o, Hazard_o,
                               ForwardA_o, ForwardB_o});
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sel, input logic [31:0] val,
                            input int dly);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val; e.due = cyc + dly;
    sb.push_back(e);
  endtask

  task automatic check_due();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        chk(sb[i].tag, obs(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  endtask

  task automatic issue(input logic [7:0] bus, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic fl);
    Bus_i = bus; IDRs_i = rs; IDRt_i = rt; IDRd_i = rd; flush_i = fl;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
    check_due();
  endtask

  task automatic settle();
    #1;
    check_due();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1;
    issue(8'h00, 0, 0, 0, 0);
    #2;
    chk("reset_all", obs(S_ALL), 0);
    @(posedge clk_i); #1;
    chk("reset_hold", obs(S_ALL), 0);
    #2 rst_i = 1'b0;

    // latency of a lw through all three stages
    issue(8'h8B, 0, 5, 0, 0);
    expect_out("lat_ex_alusrc", S_EX_ALUSRC, 1, 1);
    expect_out("lat_ex_aluop",  S_EX_ALUOP,  0, 1);
    expect_out("lat_ex_wreg",   S_EX_WREG,   5, 1);
    expect_out("lat_mem_rd",    S_MEM_RD,    1, 2);
    expect_out("lat_mem_wr",    S_MEM_WR,    0, 2);
    expect_out("lat_mem_wreg",  S_MEM_WREG,  5, 2);
    expect_out("lat_wb_rw",     S_WB_RW,     1, 3);
    expect_out("lat_wb_m2r",    S_WB_M2R,    1, 3);
    expect_out("lat_wb_wreg",   S_WB_WREG,   5, 3);
    step();
    issue(8'h00, 0, 0, 0, 0);
    step(); step(); step();

    // load-use on rs: stall one cycle, then forward from WB
    issue(8'h8B, 0, 5, 0, 0);
    step();
    issue(8'h71, 5, 2, 3, 0);
    expect_out("lu_hazard", S_HAZ, 1, 0);
    settle();
    expect_out("lu_haz_drop",   S_HAZ,       0, 1);
    expect_out("lu_bub_alusrc", S_EX_ALUSRC, 0, 1);
    expect_out("lu_bub_aluop",  S_EX_ALUOP,  0, 1);
    expect_out("lu_bub_wreg",   S_EX_WREG,   0, 1);
    expect_out("lu_mem_rd",     S_MEM_RD,    1, 1);
    expect_out("lu_ex_aluop",   S_EX_ALUOP,  3, 2);
    expect_out("lu_ex_wreg",    S_EX_WREG,   3, 2);
    expect_out("lu_fwda_wb",    S_FWDA,      1, 2);
    expect_out("lu_fwdb_rf",    S_FWDB,      0, 2);
    expect_out("lu_haz_off",    S_HAZ,       0, 2);
    step(); step();
    issue(8'h00, 0, 0, 0, 0);
    step(); step();

    // no hazard on $0 or on unrelated registers; hazard via rt
    issue(8'h8B, 0, 0, 0, 0);
    step();
    issue(8'h71, 0, 0, 3, 0);
    expect_out("hz_rt0", S_HAZ, 0, 0);
    settle();
    step();
    issue(8'h8B, 0, 5, 0, 0);
    step();
    issue(8'h71, 6, 6, 3, 0);
    expect_out("hz_other", S_HAZ, 0, 0);
    settle();
    step();
    issue(8'h8B, 0, 5, 0, 0);
    step();
    issue(8'h71, 1, 5, 3, 0);
    expect_out("hz_rt_match", S_HAZ, 1, 0);
    settle();
    step();
    issue(8'h00, 0, 0, 0, 0);
    step(); step(); step();

    // forwarding priority
    issue(8'h71, 0, 0, 3, 0); step();
    issue(8'h71, 0, 0, 3, 0); step();
    issue(8'h71, 3, 3, 9, 0);
    expect_out("fwd_a_mem", S_FWDA, 2, 1);
    expect_out("fwd_b_mem", S_FWDB, 2, 1);
    step();
    issue(8'h71, 0, 0, 3, 0); step();
    issue(8'h00, 0, 0, 0, 0); step();
    issue(8'h71, 3, 3, 9, 0);
    expect_out("fwd_a_wb", S_FWDA, 1, 1);
    expect_out("fwd_b_wb", S_FWDB, 1, 1);
    step();
    issue(8'h71, 0, 0, 0, 0); step();
    issue(8'h71, 0, 0, 0, 0); step();
    issue(8'h71, 3, 3, 9, 0);
    expect_out("fwd_a_r0", S_FWDA, 0, 1);
    expect_out("fwd_b_r0", S_FWDB, 0, 1);
    step();

    // flush squashes the ID instruction
    issue(8'h71, 0, 0, 7, 1);
    expect_out("fl_ex_wreg",  S_EX_WREG,  0, 1);
    expect_out("fl_ex_aluop", S_EX_ALUOP, 0, 1);
    expect_out("fl_mem_wreg", S_MEM_WREG, 0, 2);
    expect_out("fl_wb_rw",    S_WB_RW,    0, 3);
    expect_out("fl_wb_wreg",  S_WB_WREG,  0, 3);
    step();
    issue(8'h00, 0, 0, 0, 0);
    step(); step();

    // async reset mid-stream
    issue(8'h71, 0, 0, 1, 0); step();
    issue(8'h96, 0, 2, 0, 0); step();
    issue(8'h8B, 0, 4, 0, 0); step();
    issue(8'h00, 4, 0, 0, 0);
    expect_out("ar_pre_haz", S_HAZ, 1, 0);
    settle();
    #1 rst_i = 1'b1;
    #1 chk("ar_all_zero", obs(S_ALL), 0);
    #1 rst_i = 1'b0;
    issue(8'h32, 0, 0, 0, 0);
    expect_out("ar_ex_aluop", S_EX_ALUOP, 1, 1);
    expect_out("ar_ex_wreg",  S_EX_WREG,  0, 1);
    expect_out("ar_mem_rd",   S_MEM_RD,   0, 1);
    expect_out("ar_mem_wr",   S_MEM_WR,   0, 1);
    expect_out("ar_wb_rw",    S_WB_RW,    0, 1);
    step();
    issue(8'h00, 0, 0, 0, 0);
    step();

    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
